io_bridge: RTL and testbench

Parametrised multi-slot peripheral bridge sitting between the CPU's I/O address-space splitter and up to `N_SLOTS` peripheral devices. It decodes a flat I/O address into a slot and a register index, drives a registered single-outstanding request to the selected device, and waits for that device's `io_ready`. A per-access timeout bounds the wait. Unmapped or timed-out accesses complete with `error` instead of hanging the CPU.

---
 rtl/io_bridge.sv | 134 +++++++++++++
 tb/tb_io_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bridge.sv
// Multi-slot peripheral bridge: decodes a flat I/O address into slot + register index,
// runs one registered request at a time, and completes with error on unmapped/illegal/timeout.
module io_bridge #(
    parameter int                    ADDR_WIDTH        = 32,
    parameter int                    DATA_WIDTH        = 32,
    parameter int                    PERIPH_ADDR_WIDTH = 6,
    parameter int                    PERIPH_DATA_WIDTH = 32,
    parameter int                    N_SLOTS           = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR         = 'h80,
    parameter int                    TIMEOUT           = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   read,
    input  logic                                   write,
    input  logic [ADDR_WIDTH-1:0]                  addr,
    input  logic [DATA_WIDTH-1:0]                  wdata,
    output logic [DATA_WIDTH-1:0]                  rdata,
    output logic                                   ready,
    output logic                                   error,
    output logic [PERIPH_ADDR_WIDTH-1:0]           io_addr,
    output logic [PERIPH_DATA_WIDTH-1:0]           io_wdata,
    input  logic [N_SLOTS*PERIPH_DATA_WIDTH-1:0]   io_rdata,
    output logic [N_SLOTS-1:0]                     io_read,
    output logic [N_SLOTS-1:0]                     io_write,
    input  logic [N_SLOTS-1:0]                     io_ready,
    output logic [1:0]                             dbg_state
);

    localparam int PAW    = PERIPH_ADDR_WIDTH;
    localparam int PDW    = PERIPH_DATA_WIDTH;
    localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // One bit wider than the address so the top of the window never wraps.
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(N_SLOTS) << (PAW + 2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    logic [SLOT_W-1:0]  r_slot;
    logic               r_is_write;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_mapped;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [SLOT_W-1:0]  w_slot;
    logic [PAW-1:0]     w_index;
    logic [N_SLOTS-1:0] w_onehot;
    logic               w_sel_ready;
    logic [PDW-1:0]     w_sel_rdata;
    logic               w_timeout;

    assign w_off       = addr - BASE_ADDR;
    assign w_mapped    = (addr >= BASE_ADDR) && ({1'b0, w_off} < SPAN);
    assign w_slot      = SLOT_W'(w_off >> (PAW + 2));
    assign w_index     = w_off[PAW+1:2];
    assign w_onehot    = N_SLOTS'(1) << w_slot;
    assign w_sel_ready = io_ready[r_slot];
    assign w_sel_rdata = io_rdata[r_slot*PDW +: PDW];
    assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign dbg_state   = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_slot     <= '0;
            r_is_write <= 1'b0;
            r_cnt      <= '0;
            rdata      <= '0;
            ready      <= 1'b0;
            error      <= 1'b0;
            io_addr    <= '0;
            io_wdata   <= '0;
            io_read    <= '0;
            io_write   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (read && write) begin
                        ready   <= 1'b1;
                        error   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (read || write) begin
                        if (!w_mapped) begin
                            ready   <= 1'b1;
                            error   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_slot     <= w_slot;
                            r_is_write <= write;
                            io_addr    <= w_index;
                            io_wdata   <= wdata[PDW-1:0];
                            r_cnt      <= '0;
                            io_read    <= read  ? w_onehot : '0;
                            io_write   <= write ? w_onehot : '0;
                            r_state    <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (w_sel_ready) begin
                        io_read  <= '0;
                        io_write <= '0;
                        ready    <= 1'b1;
                        error    <= 1'b0;
                        rdata    <= r_is_write ? '0 : DATA_WIDTH'(w_sel_rdata);
                        r_state  <= S_DONE;
                    end else if (w_timeout) begin
                        io_read  <= '0;
                        io_write <= '0;
                        ready    <= 1'b1;
                        error    <= 1'b1;
                        rdata    <= '0;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    ready   <= 1'b0;
                    error   <= 1'b0;
                    rdata   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge: one instance with TIMEOUT=16, a second with the timeout disabled.
module tb_io_bridge;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         read = 1'b0;
    logic         write = 1'b0;
    logic [31:0]  addr = '0;
    logic [31:0]  wdata = '0;
    logic [127:0] io_rdata = '0;
    logic [3:0]   io_ready = '0;
    logic         read0 = 1'b0;

    logic [31:0]  rdata, rdata0;
    logic         ready, error, ready0, error0;
    logic [5:0]   io_addr, io_addr0;
    logic [31:0]  io_wdata, io_wdata0;
    logic [3:0]   io_read, io_write, io_read0, io_write0;
    logic [1:0]   dbg_state, dbg_state0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    io_bridge #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .error(error), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_read(io_read), .io_write(io_write), .io_ready(io_ready),
        .dbg_state(dbg_state)
    );

    io_bridge #(.TIMEOUT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .read(read0), .write(1'b0), .addr(32'h80), .wdata(32'h0),
        .rdata(rdata0), .ready(ready0), .error(error0), .io_addr(io_addr0), .io_wdata(io_wdata0),
        .io_rdata(128'h0), .io_read(io_read0), .io_write(io_write0), .io_ready(4'h0),
        .dbg_state(dbg_state0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        int strobe_cycles;
        int seen_ready;
        logic [3:0] prev_ready;

        // Reset values
        tick();
        check("rst_ready", ready, 0);
        check("rst_error", error, 0);
        check("rst_rdata", rdata, 0);
        check("rst_io_read", io_read, 0);
        check("rst_io_write", io_write, 0);
        check("rst_io_addr", io_addr, 0);
        check("rst_io_wdata", io_wdata, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        tick();

        // Read slot 1: 0x180 - 0x80 = 0x100 -> slot 1, index 0. Other slots' ready ignored.
        addr = 32'h180;
        read = 1'b1;
        io_rdata[32 +: 32] = 32'hDEADBEEF;
        io_ready = 4'b1101;
        tick();
        check("rd1_strobe", io_read, 4'b0010);
        check("rd1_io_addr", io_addr, 0);
        check("rd1_state", dbg_state, 1);
        tick();
        check("rd1_wait1_ready", ready, 0);
        tick();
        check("rd1_wait2_ready", ready, 0);
        check("rd1_wait2_strobe", io_read, 4'b0010);
        tick();
        check("rd1_wait3_ready", ready, 0);
        io_ready = 4'b0010;
        tick();
        check("rd1_ready", ready, 1);
        check("rd1_error", error, 0);
        check("rd1_rdata", rdata, 32'hDEADBEEF);
        check("rd1_strobe_drop", io_read, 0);
        read = 1'b0;
        io_ready = 4'b0000;
        tick();
        check("rd1_ready_pulse", ready, 0);
        check("rd1_rdata_clear", rdata, 0);

        // Write: 0x3FC - 0x80 = 0x37C -> slot 3, index 0x7C>>2 = 31
        addr = 32'h3FC;
        wdata = 32'h1234;
        write = 1'b1;
        io_ready = 4'b1000;
        tick();
        check("wr3_strobe", io_write, 4'b1000);
        check("wr3_no_read", io_read, 0);
        check("wr3_io_addr", io_addr, 31);
        check("wr3_io_wdata", io_wdata, 32'h1234);
        tick();
        check("wr3_ready", ready, 1);
        check("wr3_error", error, 0);
        check("wr3_rdata", rdata, 0);
        check("wr3_strobe_drop", io_write, 0);
        write = 1'b0;
        io_ready = 4'b0000;
        tick();
        check("wr3_addr_hold", io_addr, 31);
        check("wr3_wdata_hold", io_wdata, 32'h1234);

        // Unmapped: just below base, then first byte past the last slot
        addr = 32'h7C;
        read = 1'b1;
        tick();
        check("unmap_lo_ready", ready, 1);
        check("unmap_lo_error", error, 1);
        check("unmap_lo_strobe", io_read, 0);
        read = 1'b0;
        tick();
        addr = 32'h480;
        write = 1'b1;
        tick();
        check("unmap_hi_ready", ready, 1);
        check("unmap_hi_error", error, 1);
        check("unmap_hi_strobe", io_write, 0);
        write = 1'b0;
        tick();

        // Illegal: read and write together on a mapped address
        addr = 32'h180;
        read = 1'b1;
        write = 1'b1;
        tick();
        check("illegal_ready", ready, 1);
        check("illegal_error", error, 1);
        check("illegal_strobes", {io_read, io_write}, 0);
        read = 1'b0;
        write = 1'b0;
        tick();

        // Back-to-back reads, read held: slot 0 then slot 2 (0x280 - 0x80 = 0x200)
        io_rdata[0 +: 32]  = 32'h11111111;
        io_rdata[64 +: 32] = 32'h22222222;
        addr = 32'h80;
        read = 1'b1;
        io_ready = 4'b0001;
        tick();
        check("b2b0_strobe", io_read, 4'b0001);
        tick();
        check("b2b0_ready", ready, 1);
        check("b2b0_rdata", rdata, 32'h11111111);
        addr = 32'h280;
        io_ready = 4'b0100;
        tick();
        check("b2b_idle_ready", ready, 0);
        check("b2b_idle_state", dbg_state, 0);
        tick();
        check("b2b2_strobe", io_read, 4'b0100);
        tick();
        check("b2b2_ready", ready, 1);
        check("b2b2_error", error, 0);
        check("b2b2_rdata", rdata, 32'h22222222);
        read = 1'b0;
        io_ready = 4'b0000;
        tick();

        // Last mapped byte: 0x47F -> slot 3, index 63, addr[1:0] ignored
        addr = 32'h47F;
        write = 1'b1;
        io_ready = 4'b1000;
        tick();
        check("top_strobe", io_write, 4'b1000);
        check("top_io_addr", io_addr, 63);
        tick();
        check("top_ready", ready, 1);
        check("top_error", error, 0);
        write = 1'b0;
        io_ready = 4'b0000;
        tick();

        // Timeout: slot 0 never ready, others ready (ignored); strobe exactly 16 cycles
        addr = 32'h80;
        read = 1'b1;
        io_ready = 4'b1110;
        io_rdata[0 +: 32] = 32'hCAFEF00D;
        strobe_cycles = 0;
        seen_ready = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready) begin
                seen_ready = 1;
                break;
            end
            if (io_read == 4'b0001) strobe_cycles++;
        end
        check("to_completed", seen_ready, 1);
        check("to_strobe_cycles", strobe_cycles, 16);
        check("to_error", error, 1);
        check("to_rdata", rdata, 0);
        check("to_strobe_drop", io_read, 0);
        read = 1'b0;
        io_ready = 4'b0000;
        tick();

        // Timeout disabled: dut0 waits well past 100 cycles
        read0 = 1'b1;
        seen_ready = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (ready0) seen_ready = 1;
        end
        check("nto_no_ready", seen_ready, 0);
        check("nto_strobe_held", io_read0, 4'b0001);

        // Async reset mid-access: strobes must drop with no clock edge
        addr = 32'h180;
        read = 1'b1;
        io_ready = 4'b0000;
        tick();
        check("ra_strobe", io_read, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("ra_io_read", io_read, 0);
        check("ra_io_read0", io_read0, 0);
        check("ra_state", dbg_state, 0);
        check("ra_ready", ready, 0);
        read = 1'b0;
        read0 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Fresh access after reset
        prev_ready = 4'b0010;
        io_ready = prev_ready;
        read = 1'b1;
        tick();
        check("post_rst_strobe", io_read, 4'b0010);
        tick();
        check("post_rst_ready", ready, 1);
        check("post_rst_rdata", rdata, 32'hDEADBEEF);
        read = 1'b0;
        io_ready = 4'b0000;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
